load_store_unit: RTL and testbench
==================================

Name: load_store_unit

Overview:
Multi-cycle load/store unit that replaces the combinational store/load path of the single-cycle datapath. It takes one data-memory request from the core and runs a wait-state handshake on the data bus. It generates little-endian byte enables, write-lane replication and load extraction for a parametrised data width. It stalls the core until completion and reports address-error and bus-timeout exceptions to COP0.

Parameters:
DATA_W, 32, bus/register data width; 32 or 64 only.
ADDR_W, 32, byte-address width.
TIMEOUT, 255, maximum ACCESS cycles before bus error; 0 disables the timeout.

Ports:
iCLK  in  1  clock
iRST  in  1  synchronous active-high reset
iReq  in  1  core request; held by core until oDone or oException
iWrite  in  1  1=store, 0=load
iSize  in  2  00 byte, 01 half, 10 word, 11 dword (legal only if DATA_W=64)
iUnsigned  in  1  zero-extend load (lbu/lhu/lwu)
iAddress  in  ADDR_W  byte address
iWriteData  in  DATA_W  store data, right-justified
oStall  out  1  freeze PC/pipeline
oDone  out  1  one-cycle completion pulse
oReadData  out  DATA_W  extended load result, valid while oDone=1
oException  out  1  one-cycle exception pulse
oExcCode  out  5  4 AdEL, 5 AdES, 7 DBE; 0 otherwise
oBusRead  out  1  bus read strobe
oBusWrite  out  1  bus write strobe
oBusByteEnable  out  DATA_W/8  lane enables
oBusAddress  out  ADDR_W  lane-aligned address (low log2(DATA_W/8) bits zero)
oBusWriteData  out  DATA_W  replicated store data
iBusReadData  in  DATA_W  bus read data
iBusReady  in  1  slave completes the access this cycle

Behaviour:
- Reset: state IDLE. All outputs 0. Timeout counter 0. Request registers cleared.
- States are IDLE, ACCESS, DONE, ERR.
- Alignment is checked combinationally in IDLE:
  - half needs addr[0]=0; word needs addr[1:0]=0; dword needs addr[2:0]=0.
  - size 11 with DATA_W=32 is misaligned.
- IDLE, iReq=1 and misaligned:
  - oException=1 and oExcCode=4 (load) or 5 (store) in the same cycle.
  - oStall=0. No bus strobe. Stay in IDLE.
- IDLE, iReq=1 and aligned:
  - oStall=1 combinationally.
  - Register address, size, unsigned flag, direction and lane-formatted data.
  - Go to ACCESS.
- ACCESS:
  - Bus outputs are driven only from registers and are stable every ACCESS cycle.
  - oBusRead or oBusWrite is 1. oStall=1.
  - iBusReady=1: capture iBusReadData, then go to DONE.
  - Otherwise increment the counter. When counter reaches TIMEOUT-1 with no ready, go to ERR.
- DONE: oDone=1, oStall=0, strobes 0, oReadData valid. Next state IDLE unconditionally; iReq is ignored here.
- ERR: oException=1, oExcCode=7, oStall=0, strobes 0. Next state IDLE.
- Minimum latency: request cycle 0, ready in cycle 1, oDone in cycle 2. Each extra wait cycle adds one.
- Lanes:
  - lane = addr[log2(DATA_W/8)-1:0], little-endian.
  - Byte enable is the size mask (1/3/F/FF) shifted left by lane.
  - Store data: byte replicated to every lane, half to every half-lane, word to every word-lane (DATA_W=64).
  - Load: select lanes by the registered address, then sign-extend or zero-extend to DATA_W. Dword is passed through.
- iBusReady outside ACCESS is ignored.
- Reset mid-transaction: return to IDLE and drop strobes at that edge. No oDone or oException for the abandoned access.
- oExcCode is 0 whenever oException=0.

Optional Feature:
LSU_LL_SC_EN adds ports iLinked (1, in) and iClearLink (1, in), plus an internal link bit and link address.
- Load with iLinked=1 (ll): sets link=1 and latches the lane-aligned address in DONE.
- Store with iLinked=1 (sc):
  - Succeeds only if link=1 and the address matches. It then performs a normal bus write, and oReadData=1 in DONE.
  - On failure there is no bus access; go IDLE to DONE directly (1-cycle stall) with oReadData=0.
- Link is cleared by any completed store to the linked address, by iClearLink (eret/exception), and by reset.
- Without the macro: no extra ports, and every access is an ordinary load/store.

Decomposition:
- Package lsu_pkg holds:
  - size encodings SIZE_B/H/W/D and state enum lsu_state_t;
  - exception codes EXC_ADEL=4, EXC_ADES=5, EXC_DBE=7.
- Sub-module lsu_lane_align is purely combinational and parametrised by DATA_W. It does alignment check, byte-enable generation, store replication and load extraction/extension. The FSM, counter and link state stay in load_store_unit.

Test Plan:
1. DATA_W=32, load byte signed, addr 0x1003, bus data 0x80FF_0000, iBusReady in the first ACCESS cycle -> BE=1000, bus addr 0x1000, oDone in cycle 2, oReadData=0xFFFF_FF80.
2. Store half 0xBEEF to addr 0x2002, iBusReady held low 3 cycles -> BE=1100, WriteData=0xBEEF_BEEF, strobes stable 4 cycles, oDone one cycle after ready.
3. Load word at addr 0x0006 -> oException=1, oExcCode=4 in the same cycle, no oBusRead, oStall=0. Store half at 0x0001 -> code 5.
4. TIMEOUT=4, iBusReady never asserted -> exactly 4 ACCESS cycles, then ERR pulse with oExcCode=7, then IDLE.
5. iRST asserted in the second ACCESS cycle, iBusReady=1 the next cycle -> strobes 0 after the edge, no oDone, no oException.
6. DATA_W=64, load word unsigned at 0x...4 with data 0x8000_0001_xxxx_xxxx -> BE=F0, oReadData=0x0000_0000_8000_0001.
   - With LSU_LL_SC_EN: ll at 0x40, sc at 0x40 -> write issued, oReadData=1.
   - Repeat sc -> no bus write, oReadData=0.

Source files
------------

// File: rtl/lsu_pkg.sv
// lsu_pkg: access-size encodings, FSM states and COP0 exception codes shared
// by the load/store unit and its lane-formatting helper.
package lsu_pkg;

    localparam logic [1:0] SIZE_B = 2'b00;
    localparam logic [1:0] SIZE_H = 2'b01;
    localparam logic [1:0] SIZE_W = 2'b10;
    localparam logic [1:0] SIZE_D = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        ERR
    } lsu_state_t;

    localparam logic [4:0] EXC_ADEL = 5'd4;
    localparam logic [4:0] EXC_ADES = 5'd5;
    localparam logic [4:0] EXC_DBE  = 5'd7;

    // Unshifted lane mask covering one access of the given size.
    function automatic logic [7:0] sizeMask(input logic [1:0] size);
        case (size)
            SIZE_B:  sizeMask = 8'h01;
            SIZE_H:  sizeMask = 8'h03;
            SIZE_W:  sizeMask = 8'h0F;
            default: sizeMask = 8'hFF;
        endcase
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// lsu_lane_align: combinational little-endian lane logic -- alignment check,
// byte enables, store-data replication and load extraction/extension.
module lsu_lane_align
    import lsu_pkg::*;
#(
    parameter int DATA_W = 32,
    localparam int NB     = DATA_W / 8,
    localparam int LANE_W = $clog2(NB)
) (
    input  logic [1:0]        reqSize_i,
    input  logic [LANE_W-1:0] reqLane_i,
    input  logic [DATA_W-1:0] storeData_i,
    input  logic [1:0]        loadSize_i,
    input  logic [LANE_W-1:0] loadLane_i,
    input  logic              loadUnsigned_i,
    input  logic [DATA_W-1:0] busData_i,
    output logic              misaligned_o,
    output logic [NB-1:0]     byteEnable_o,
    output logic [DATA_W-1:0] storeData_o,
    output logic [DATA_W-1:0] loadData_o
);

    logic [2:0]        reqLane3;
    logic [DATA_W-1:0] shifted;

    // Widen the lane to three bits so the dword check is uniform for both widths.
    assign reqLane3     = 3'(reqLane_i);
    assign byteEnable_o = NB'(sizeMask(reqSize_i) << reqLane3);
    assign shifted      = busData_i >> {loadLane_i, 3'b000};

    always_comb begin
        misaligned_o = 1'b0;
        case (reqSize_i)
            SIZE_H:  misaligned_o = reqLane3[0];
            SIZE_W:  misaligned_o = |reqLane3[1:0];
            SIZE_D:  misaligned_o = (DATA_W == 32) || (|reqLane3);
            default: misaligned_o = 1'b0;
        endcase
    end

    always_comb begin
        storeData_o = storeData_i;
        case (reqSize_i)
            SIZE_B:  storeData_o = {(DATA_W/8){storeData_i[7:0]}};
            SIZE_H:  storeData_o = {(DATA_W/16){storeData_i[15:0]}};
            SIZE_W:  storeData_o = {(DATA_W/32){storeData_i[31:0]}};
            default: storeData_o = storeData_i;
        endcase
    end

    // Extend through a 64-bit intermediate; truncation keeps the 32-bit build exact.
    always_comb begin
        loadData_o = shifted;
        case (loadSize_i)
            SIZE_B:  loadData_o = DATA_W'({{56{!loadUnsigned_i && shifted[7]}}, shifted[7:0]});
            SIZE_H:  loadData_o = DATA_W'({{48{!loadUnsigned_i && shifted[15]}}, shifted[15:0]});
            SIZE_W:  loadData_o = DATA_W'({{32{!loadUnsigned_i && shifted[31]}}, shifted[31:0]});
            default: loadData_o = shifted;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: multi-cycle data-memory access with a wait-state bus
// handshake, stall control and AdEL/AdES/DBE reporting. LSU_LL_SC_EN adds ll/sc.
module load_store_unit
    import lsu_pkg::*;
#(
    parameter int          DATA_W  = 32,
    parameter int          ADDR_W  = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                iCLK,
    input  logic                iRST,
    input  logic                iReq,
    input  logic                iWrite,
    input  logic [1:0]          iSize,
    input  logic                iUnsigned,
    input  logic [ADDR_W-1:0]   iAddress,
    input  logic [DATA_W-1:0]   iWriteData,
`ifdef LSU_LL_SC_EN
    input  logic                iLinked,
    input  logic                iClearLink,
`endif
    output logic                oStall,
    output logic                oDone,
    output logic [DATA_W-1:0]   oReadData,
    output logic                oException,
    output logic [4:0]          oExcCode,
    output logic                oBusRead,
    output logic                oBusWrite,
    output logic [DATA_W/8-1:0] oBusByteEnable,
    output logic [ADDR_W-1:0]   oBusAddress,
    output logic [DATA_W-1:0]   oBusWriteData,
    input  logic [DATA_W-1:0]   iBusReadData,
    input  logic                iBusReady
);

    localparam int NB     = DATA_W / 8;
    localparam int LANE_W = $clog2(NB);
    localparam int CNT_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    lsu_state_t state_q, state_d;
    logic [CNT_W-1:0]  count_q, count_d;

    logic [ADDR_W-1:0] busAddr_q;
    logic [LANE_W-1:0] lane_q;
    logic [1:0]        size_q;
    logic              unsignedLoad_q;
    logic              write_q;
    logic [DATA_W-1:0] writeData_q;
    logic [NB-1:0]     byteEnable_q;
    logic [DATA_W-1:0] readData_q;

    logic              misaligned;
    logic [NB-1:0]     fmtBe;
    logic [DATA_W-1:0] fmtData;
    logic [DATA_W-1:0] loadData;
    logic [DATA_W-1:0] doneData;
    logic [ADDR_W-1:0] reqAlignedAddr;
    logic              acceptReq;
    logic              scFail;

    assign reqAlignedAddr = {iAddress[ADDR_W-1:LANE_W], {LANE_W{1'b0}}};
    assign acceptReq      = (state_q == IDLE) && iReq && !misaligned;

    lsu_lane_align #(.DATA_W(DATA_W)) uAlign (
        .reqSize_i      (iSize),
        .reqLane_i      (iAddress[LANE_W-1:0]),
        .storeData_i    (iWriteData),
        .loadSize_i     (size_q),
        .loadLane_i     (lane_q),
        .loadUnsigned_i (unsignedLoad_q),
        .busData_i      (readData_q),
        .misaligned_o   (misaligned),
        .byteEnable_o   (fmtBe),
        .storeData_o    (fmtData),
        .loadData_o     (loadData)
    );

`ifdef LSU_LL_SC_EN
    logic              linked_q;
    logic              scPass_q;
    logic              link_q;
    logic [ADDR_W-1:0] linkAddr_q;

    // A failed sc skips the bus entirely and completes straight from IDLE.
    assign scFail   = iLinked && iWrite && !(link_q && (linkAddr_q == reqAlignedAddr));
    assign doneData = (linked_q && write_q) ? DATA_W'(scPass_q) : (write_q ? '0 : loadData);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            linked_q <= 1'b0;
            scPass_q <= 1'b0;
        end else if (acceptReq) begin
            linked_q <= iLinked;
            scPass_q <= !scFail;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST || iClearLink) begin
            link_q     <= 1'b0;
            linkAddr_q <= '0;
        end else if (state_q == DONE && linked_q && !write_q) begin
            link_q     <= 1'b1;
            linkAddr_q <= busAddr_q;
        end else if (state_q == DONE && write_q && (!linked_q || scPass_q)
                     && busAddr_q == linkAddr_q) begin
            link_q <= 1'b0;
        end
    end
`else
    assign scFail   = 1'b0;
    assign doneData = write_q ? '0 : loadData;
`endif

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            busAddr_q      <= '0;
            lane_q         <= '0;
            size_q         <= SIZE_B;
            unsignedLoad_q <= 1'b0;
            write_q        <= 1'b0;
            writeData_q    <= '0;
            byteEnable_q   <= '0;
            readData_q     <= '0;
        end else begin
            if (acceptReq) begin
                busAddr_q      <= reqAlignedAddr;
                lane_q         <= iAddress[LANE_W-1:0];
                size_q         <= iSize;
                unsignedLoad_q <= iUnsigned;
                write_q        <= iWrite;
                writeData_q    <= fmtData;
                byteEnable_q   <= fmtBe;
            end
            if (state_q == ACCESS && iBusReady) begin
                readData_q <= iBusReadData;
            end
        end
    end

    // Bus outputs come only from the request registers, gated by the ACCESS state.
    always_comb begin
        state_d        = state_q;
        count_d        = count_q;
        oStall         = 1'b0;
        oDone          = 1'b0;
        oReadData      = '0;
        oException     = 1'b0;
        oExcCode       = 5'd0;
        oBusRead       = 1'b0;
        oBusWrite      = 1'b0;
        oBusByteEnable = '0;
        oBusAddress    = '0;
        oBusWriteData  = '0;
        case (state_q)
            IDLE: begin
                if (iReq) begin
                    if (misaligned) begin
                        oException = 1'b1;
                        oExcCode   = iWrite ? EXC_ADES : EXC_ADEL;
                    end else begin
                        oStall  = 1'b1;
                        count_d = '0;
                        state_d = scFail ? DONE : ACCESS;
                    end
                end
            end
            ACCESS: begin
                oStall         = 1'b1;
                oBusRead       = !write_q;
                oBusWrite      = write_q;
                oBusByteEnable = byteEnable_q;
                oBusAddress    = busAddr_q;
                oBusWriteData  = writeData_q;
                if (iBusReady) begin
                    state_d = DONE;
                end else if ((TIMEOUT != 0) && (count_q == CNT_W'(TIMEOUT - 1))) begin
                    state_d = ERR;
                end else begin
                    count_d = count_q + CNT_W'(1);
                end
            end
            DONE: begin
                oDone     = 1'b1;
                oReadData = doneData;
                state_d   = IDLE;
            end
            ERR: begin
                oException = 1'b1;
                oExcCode   = EXC_DBE;
                state_d    = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: directed vectors against a 32-bit unit (TIMEOUT=4) and a
// 64-bit unit (TIMEOUT=255); ll/sc vectors run when LSU_LL_SC_EN is defined.
module tb_load_store_unit;
    import lsu_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    logic        reqA, writeA, unsA, readyA, linkedA, clearA;
    logic [1:0]  sizeA;
    logic [31:0] addrA, wdA, busRdA;
    logic        stallA, doneA, excA, brdA, bwrA;
    logic [4:0]  codeA;
    logic [3:0]  beA;
    logic [31:0] baddrA, bwdA, rdataA;

    logic        reqB, writeB, unsB, readyB, linkedB, clearB;
    logic [1:0]  sizeB;
    logic [31:0] addrB;
    logic [63:0] wdB, busRdB;
    logic        stallB, doneB, excB, brdB, bwrB;
    logic [4:0]  codeB;
    logic [7:0]  beB;
    logic [31:0] baddrB;
    logic [63:0] bwdB, rdataB;

    int checkCount = 0;
    int errorCount = 0;
    int accessCycles;

    logic        useB = 1'b0;
    logic        stallS, doneS, excS, brdS, bwrS;
    logic [4:0]  codeS;
    logic [7:0]  beS;
    logic [31:0] baddrS;
    logic [63:0] bwdS, rdataS;

    load_store_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(4)) dutA (
        .iCLK(clk), .iRST(rst), .iReq(reqA), .iWrite(writeA), .iSize(sizeA),
        .iUnsigned(unsA), .iAddress(addrA), .iWriteData(wdA),
`ifdef LSU_LL_SC_EN
        .iLinked(linkedA), .iClearLink(clearA),
`endif
        .oStall(stallA), .oDone(doneA), .oReadData(rdataA), .oException(excA),
        .oExcCode(codeA), .oBusRead(brdA), .oBusWrite(bwrA), .oBusByteEnable(beA),
        .oBusAddress(baddrA), .oBusWriteData(bwdA), .iBusReadData(busRdA),
        .iBusReady(readyA)
    );

    load_store_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(255)) dutB (
        .iCLK(clk), .iRST(rst), .iReq(reqB), .iWrite(writeB), .iSize(sizeB),
        .iUnsigned(unsB), .iAddress(addrB), .iWriteData(wdB),
`ifdef LSU_LL_SC_EN
        .iLinked(linkedB), .iClearLink(clearB),
`endif
        .oStall(stallB), .oDone(doneB), .oReadData(rdataB), .oException(excB),
        .oExcCode(codeB), .oBusRead(brdB), .oBusWrite(bwrB), .oBusByteEnable(beB),
        .oBusAddress(baddrB), .oBusWriteData(bwdB), .iBusReadData(busRdB),
        .iBusReady(readyB)
    );

    always_comb begin
        if (useB) begin
            stallS = stallB; doneS = doneB; excS = excB; brdS = brdB; bwrS = bwrB;
            codeS = codeB; beS = beB; baddrS = baddrB; bwdS = bwdB; rdataS = rdataB;
        end else begin
            stallS = stallA; doneS = doneA; excS = excA; brdS = brdA; bwrS = bwrA;
            codeS = codeA; beS = {4'b0, beA}; baddrS = baddrA;
            bwdS = {32'b0, bwdA}; rdataS = {32'b0, rdataA};
        end
    end

    task automatic checkOutput(input string tag, input logic [63:0] actual,
                               input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got %h, expected %h", tag, actual, expected);
        end
    endtask

    // One full transaction; ready is raised in the last of (waits+1) ACCESS cycles.
    task automatic applyStimulus(input string name, input logic b, input logic wr,
                                 input logic [1:0] sz, input logic uns,
                                 input logic [31:0] addr, input logic [63:0] wd,
                                 input logic [63:0] bd, input int waits,
                                 input logic [7:0] expBe, input logic [31:0] expAddr,
                                 input logic [63:0] expWd, input logic chkRd,
                                 input logic [63:0] expRd);
        @(posedge clk); #1;
        useB = b;
        if (b) begin
            reqB = 1'b1; writeB = wr; sizeB = sz; unsB = uns; addrB = addr;
            wdB = wd; busRdB = bd; readyB = 1'b0;
        end else begin
            reqA = 1'b1; writeA = wr; sizeA = sz; unsA = uns; addrA = addr;
            wdA = wd[31:0]; busRdA = bd[31:0]; readyA = 1'b0;
        end
        #1;
        checkOutput({name, " stall on request"}, stallS, 1'b1);
        checkOutput({name, " no strobe on request"}, brdS | bwrS, 1'b0);
        for (int i = 0; i <= waits; i++) begin
            @(posedge clk); #1;
            checkOutput({name, " read strobe"}, brdS, !wr);
            checkOutput({name, " write strobe"}, bwrS, wr);
            checkOutput({name, " byte enable"}, beS, expBe);
            checkOutput({name, " bus address"}, baddrS, expAddr);
            if (wr) checkOutput({name, " bus write data"}, bwdS, expWd);
            checkOutput({name, " stall in access"}, stallS, 1'b1);
            if (b) readyB = (i == waits);
            else   readyA = (i == waits);
        end
        @(posedge clk); #1;
        checkOutput({name, " done"}, doneS, 1'b1);
        checkOutput({name, " stall released"}, stallS, 1'b0);
        checkOutput({name, " strobes dropped"}, brdS | bwrS, 1'b0);
        if (chkRd) checkOutput({name, " read data"}, rdataS, expRd);
        reqA = 1'b0; reqB = 1'b0; readyA = 1'b0; readyB = 1'b0;
        @(posedge clk); #1;
        checkOutput({name, " done is one cycle"}, doneS, 1'b0);
    endtask

    initial begin
        rst = 1'b1;
        reqA = 0; writeA = 0; unsA = 0; readyA = 0; linkedA = 0; clearA = 0;
        sizeA = SIZE_B; addrA = '0; wdA = '0; busRdA = '0;
        reqB = 0; writeB = 0; unsB = 0; readyB = 0; linkedB = 0; clearB = 0;
        sizeB = SIZE_B; addrB = '0; wdB = '0; busRdB = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset stall", stallA, 1'b0);
        checkOutput("reset done", doneA, 1'b0);
        checkOutput("reset exception", excA, 1'b0);
        checkOutput("reset exc code", codeA, 5'd0);
        checkOutput("reset strobes", brdA | bwrA, 1'b0);
        checkOutput("reset byte enable", beA, 4'b0);
        checkOutput("reset bus address", baddrA, 32'h0);
        checkOutput("reset read data", rdataA, 32'h0);
        checkOutput("reset stall 64", stallB, 1'b0);
        rst = 1'b0;

        applyStimulus("lb A", 0, 0, SIZE_B, 0, 32'h1003, 0, 64'h80FF_0000, 0,
                      8'b1000, 32'h1000, 0, 1, 64'hFFFF_FF80);
        applyStimulus("sh A", 0, 1, SIZE_H, 0, 32'h2002, 64'hBEEF, 0, 3,
                      8'b1100, 32'h2000, 64'hBEEF_BEEF, 0, 0);
        applyStimulus("lhu A", 0, 0, SIZE_H, 1, 32'h0002, 0, 64'h8001_1234, 1,
                      8'b1100, 32'h0000, 0, 1, 64'h0000_8001);
        applyStimulus("sb A", 0, 1, SIZE_B, 0, 32'h0001, 64'h5A, 0, 0,
                      8'b0010, 32'h0000, 64'h5A5A_5A5A, 0, 0);

        @(posedge clk); #1;
        useB = 1'b0; reqA = 1; writeA = 0; sizeA = SIZE_W; addrA = 32'h6;
        #1;
        checkOutput("lw misaligned exception", excA, 1'b1);
        checkOutput("lw misaligned code", codeA, EXC_ADEL);
        checkOutput("lw misaligned no read", brdA, 1'b0);
        checkOutput("lw misaligned no stall", stallA, 1'b0);
        reqA = 0;
        @(posedge clk); #1;
        reqA = 1; writeA = 1; sizeA = SIZE_H; addrA = 32'h1;
        #1;
        checkOutput("sh misaligned exception", excA, 1'b1);
        checkOutput("sh misaligned code", codeA, EXC_ADES);
        checkOutput("sh misaligned no write", bwrA, 1'b0);
        reqA = 0;
        @(posedge clk); #1;
        checkOutput("idle exception clear", excA, 1'b0);
        checkOutput("idle exc code zero", codeA, 5'd0);

        @(posedge clk); #1;
        reqA = 1; writeA = 0; sizeA = SIZE_W; addrA = 32'h3000; readyA = 0;
        accessCycles = 0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (brdA) accessCycles++;
            else break;
        end
        checkOutput("timeout access cycles", 64'(accessCycles), 64'd4);
        checkOutput("timeout exception", excA, 1'b1);
        checkOutput("timeout code", codeA, EXC_DBE);
        checkOutput("timeout stall", stallA, 1'b0);
        reqA = 0;
        @(posedge clk); #1;
        checkOutput("after timeout exception", excA, 1'b0);
        checkOutput("after timeout done", doneA, 1'b0);

        @(posedge clk); #1;
        reqA = 1; writeA = 0; sizeA = SIZE_W; addrA = 32'h4000; readyA = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("pre-reset read strobe", brdA, 1'b1);
        rst = 1; reqA = 0;
        @(posedge clk); #1;
        checkOutput("reset drops strobe", brdA, 1'b0);
        checkOutput("reset drops stall", stallA, 1'b0);
        rst = 0; readyA = 1;
        @(posedge clk); #1;
        checkOutput("abandoned no done", doneA, 1'b0);
        checkOutput("abandoned no exception", excA, 1'b0);
        readyA = 0;
        @(posedge clk); #1;
        checkOutput("abandoned still no done", doneA | excA, 1'b0);

        applyStimulus("lwu B", 1, 0, SIZE_W, 1, 32'h1004, 0, 64'h8000_0001_DEAD_BEEF, 0,
                      8'hF0, 32'h1000, 0, 1, 64'h0000_0000_8000_0001);
        applyStimulus("lw B", 1, 0, SIZE_W, 0, 32'h1004, 0, 64'h8000_0001_DEAD_BEEF, 0,
                      8'hF0, 32'h1000, 0, 1, 64'hFFFF_FFFF_8000_0001);
        applyStimulus("lh B", 1, 0, SIZE_H, 0, 32'h0006, 0, 64'h8765_0000_0000_0000, 0,
                      8'hC0, 32'h0000, 0, 1, 64'hFFFF_FFFF_FFFF_8765);
        applyStimulus("ld B", 1, 0, SIZE_D, 0, 32'h3008, 0, 64'h0123_4567_89AB_CDEF, 1,
                      8'hFF, 32'h3008, 0, 1, 64'h0123_4567_89AB_CDEF);
        applyStimulus("sb B", 1, 1, SIZE_B, 0, 32'h2005, 64'hA5, 0, 0,
                      8'h20, 32'h2000, 64'hA5A5_A5A5_A5A5_A5A5, 0, 0);
        applyStimulus("sw B", 1, 1, SIZE_W, 0, 32'h0010, 64'hCAFE_F00D, 0, 0,
                      8'h0F, 32'h0010, 64'hCAFE_F00D_CAFE_F00D, 0, 0);

`ifdef LSU_LL_SC_EN
        linkedA = 1;
        applyStimulus("ll A", 0, 0, SIZE_W, 0, 32'h40, 0, 64'h1111_1111, 0,
                      8'hF, 32'h40, 0, 1, 64'h1111_1111);
        applyStimulus("sc A", 0, 1, SIZE_W, 0, 32'h40, 64'h77, 0, 0,
                      8'hF, 32'h40, 64'h77, 1, 64'h1);
        @(posedge clk); #1;
        useB = 0; reqA = 1; writeA = 1; sizeA = SIZE_W; addrA = 32'h40;
        #1;
        checkOutput("sc fail stall", stallA, 1'b1);
        @(posedge clk); #1;
        checkOutput("sc fail done", doneA, 1'b1);
        checkOutput("sc fail no write", bwrA, 1'b0);
        checkOutput("sc fail result", rdataA, 32'h0);
        reqA = 0; linkedA = 0;
        @(posedge clk); #1;
`endif

        $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
        $finish;
    end

endmodule
